alu_exec: RTL and testbench

//  Execute-stage ALU driven by the 14-bit one-hot aluop word from the ALU control decoder.
//  ADD/SLL/SRA/XOR/AND/OR and branch compares complete in 1 cycle.
//  MUL/MULH use an iterative signed shift-add multiplier, stalling upstream via in_ready.

---
 rtl/alu_exec_if.sv | 19 +
 rtl/alu_exec.sv | 95 +++++++++
 tb/tb_alu_exec.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if: issue/result bundle between the decode stage and the execute ALU
interface alu_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        branch_taken;
  modport master (
    output in_valid, aluop, a, b,
    input  in_ready, out_valid, result, branch_taken
  );
  modport slave (
    input  in_valid, aluop, a, b,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with single-cycle ops and an iterative signed shift-add multiplier
// Optional ALU_EARLY_TERM_EN: stop multiplying once the remaining multiplier bits are all zero.
module alu_exec #(
  parameter int RADIX_BITS = 2
) (
  input logic       clock,
  input logic       reset,
  alu_exec_if.slave bus
);
  localparam int N  = 32 / RADIX_BITS;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, MULB, MFIX} state_t;
  state_t        state;
  logic [63:0]   acc, mcand, prod;
  logic [31:0]   mplier, mag_a, mag_b, alu_res, a, b;
  logic [13:0]   op;
  logic [CW-1:0] count;
  logic          sign, mulh, rbus0, br, is_mul, accept, mul_done;
  always_comb begin
    op      = bus.aluop;
    a       = bus.a;
    b       = bus.b;
    accept  = bus.in_valid & bus.in_ready;
    is_mul  = op[13:8] == '0 && (op[7] | op[6]);
    alu_res = op[5]  ? '0 :
              op[13] ? a + b :
              op[12] ? a << b[4:0] :
              op[11] ? 32'($signed(a) >>> b[4:0]) :
              op[10] ? a ^ b :
              op[9]  ? a & b :
              op[8]  ? a | b : '0;
    br      = !op[0] & ((op[4] & (a == b)) | (op[3] & (a != b)) |
              (op[2] & ($signed(a) < $signed(b))) | (op[1] & ($signed(a) >= $signed(b))));
    // two's-complement negation of 0x80000000 yields unsigned 2^31, which is the magnitude we want
    mag_a   = a[31] ? -a : a;
    mag_b   = b[31] ? -b : b;
    prod    = sign ? -acc : acc;
`ifdef ALU_EARLY_TERM_EN
    mul_done = count == CW'(N - 1) || (mplier >> RADIX_BITS) == '0;
`else
    mul_done = count == CW'(N - 1);
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.result       <= '0;
      bus.branch_taken <= 1'b0;
      count            <= '0;
      acc              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      sign             <= 1'b0;
      mulh             <= 1'b0;
      rbus0            <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus.branch_taken <= br;
          if (is_mul) begin
            mcand        <= {32'd0, mag_a};
            mplier       <= mag_b;
            acc          <= '0;
            sign         <= a[31] ^ b[31];
            mulh         <= !op[7];
            rbus0        <= op[5];
            count        <= '0;
            bus.in_ready <= 1'b0;
            state        <= MULB;
          end else begin
            bus.result    <= alu_res;
            bus.out_valid <= 1'b1;
          end
        end
        MULB: begin
          acc    <= acc + mcand * 64'(mplier[RADIX_BITS-1:0]);
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          count  <= count + CW'(1);
          if (mul_done) state <= MFIX;
        end
        MFIX: begin
          bus.result    <= rbus0 ? '0 : mulh ? prod[63:32] : prod[31:0];
          bus.out_valid <= 1'b1;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec against a plain-arithmetic reference model
module tb_alu_exec;
  localparam int R = 2;
  localparam logic [13:0] ADD = 14'h2000, SLL = 14'h1000, SRA = 14'h0800, XOR = 14'h0400,
                          AND = 14'h0200, OR = 14'h0100, MUL = 14'h0080, MULH = 14'h0040,
                          RB0 = 14'h0020, EQ = 14'h0010, NE = 14'h0008, LT = 14'h0004,
                          GE = 14'h0002, BB0 = 14'h0001;
  typedef struct {
    logic [31:0] r;
    logic        br;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  exp_t sb[$];
  alu_exec_if bus();
  alu_exec dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d", name, got, want, cyc);
    end
  endtask
  function automatic int mul_edges(input logic [31:0] y);
`ifdef ALU_EARLY_TERM_EN
    logic [31:0] m;
    int bits, it;
    m = y[31] ? -y : y;
    bits = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
    it = (bits + R - 1) / R;
    return (it < 1 ? 1 : it) + 1;
`else
    return 32 / R + 1;
`endif
  endfunction
  task automatic model(input logic [13:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic br, output int edges);
    int hi;
    logic [63:0] p;
    hi = -1;
    for (int i = 6; i <= 13; i++) if (op[i]) hi = i;
    p = longint'($signed(x)) * longint'($signed(y));
    case (hi)
      13: r = x + y;
      12: r = x << y[4:0];
      11: r = 32'($signed(x) >>> y[4:0]);
      10: r = x ^ y;
      9: r = x & y;
      8: r = x | y;
      7: r = p[31:0];
      6: r = p[63:32];
      default: r = 32'd0;
    endcase
    if (op[5]) r = 32'd0;
    br = !op[0] && ((op[4] && x == y) || (op[3] && x != y) ||
         (op[2] && $signed(x) < $signed(y)) || (op[1] && $signed(x) >= $signed(y)));
    edges = (hi == 7 || hi == 6) ? mul_edges(y) : 0;
  endtask
  task automatic issue(input logic [13:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit push = 1'b1);
    exp_t e;
    int edges;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.aluop = op;
    bus.a = x;
    bus.b = y;
    for (int t = 0; !bus.in_ready && t < 200; t++) @(negedge clk);
    if (!bus.in_ready) begin
      $display("FAIL in_ready timeout op=%h", op);
      $fatal(1, "in_ready stuck low");
    end
    model(op, x, y, e.r, e.br, edges);
    e.due = cyc + 1 + edges;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; sb.size() != 0 && t < 200; t++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL spurious out_valid result=%h want no pulse", bus.result);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(bus.result), 64'(e.r));
        chk("branch", 64'(bus.branch_taken), 64'(e.br));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end
  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'(signed'($urandom_range(0, 40)) - 20);
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int low;
    logic [13:0] op;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.aluop = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_branch", 64'(bus.branch_taken), 64'd0);
    rst = 1'b0;
    issue(ADD, 32'd5, 32'd7);
    issue(SRA, 32'h8000_0000, 32'd4);
    issue(SLL, 32'd1, 32'd31);
    issue(XOR, 32'hF0F0_1234, 32'h0FF0_4321);
    issue(ADD | MUL, 32'hFFFF_FFFF, 32'd2);
    drain();
    issue(MUL, 32'hFFFF_FFFD, 32'd7);
    low = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      low++;
    end
    chk("mul_in_ready_low", 64'(low), 64'(mul_edges(32'd7)));
    drain();
    issue(MULH, 32'h8000_0000, 32'h8000_0000);
    issue(MUL, 32'h8000_0000, 32'h8000_0000);
    issue(MULH, 32'h1234_5678, 32'hFEDC_BA98);
    issue(MUL, 32'd12345, 32'd0);
    issue(LT | RB0, 32'hFFFF_FFFF, 32'd1);
    issue(GE | RB0, 32'hFFFF_FFFF, 32'd1);
    issue(ADD | BB0 | EQ | NE, 32'd3, 32'd4);
    issue(EQ | RB0, 32'd9, 32'd9);
    issue(14'd0, 32'd9, 32'd9);
    drain();
    issue(MUL, 32'd123456, 32'hFFFF_F000, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(ADD, 32'd10, 32'd20);
    drain();
    repeat (150) begin
      case ($urandom_range(0, 3))
        0: op = 14'($urandom);
        1: op = (14'd1 << $urandom_range(6, 13)) | ($urandom_range(0, 3) == 0 ? 14'($urandom_range(0, 63)) : 14'd0);
        2: op = (14'd1 << $urandom_range(1, 4)) | ($urandom_range(0, 1) ? RB0 : ADD);
        default: op = $urandom_range(0, 1) ? MUL : MULH;
      endcase
      issue(op, rand_operand(), rand_operand());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
